mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory controller between two requesters.
//  - The CPU control FSM is the primary requester.
//  - The debug/loader port is the secondary requester.
//  - Grants round-robin, holds each grant for one complete transaction, and returns read data and a done pulse to the winner.
//  - Sits between ctrl/debug and the memory controller, replacing the direct mem_ctrl_op/mem_op_done connection.
// PARAMETERS
//  DATA_BUS_WIDTH  8    data width of all rdata/wdata ports
//  ADDR_WIDTH      8    memory address width
//  MAX_WAIT        255  cycles a grant may wait for mem_done before timeout; must be >=2
// PORTS
//  clock      in   1               system clock; all logic on posedge
//  reset      in   1               synchronous, active-high
//  cpu_op     in   mem_ctrl_op_e   CPU request (MEM_NOP = idle)
//  cpu_addr   in   ADDR_WIDTH      CPU address
//  cpu_wdata  in   DATA_BUS_WIDTH  CPU write data
//  cpu_rdata  out  DATA_BUS_WIDTH  read data returned to CPU
//  cpu_done   out  1               1-cycle pulse: CPU transaction complete
//  dbg_op     in   mem_ctrl_op_e   debug request (MEM_NOP = idle)
//  dbg_addr   in   ADDR_WIDTH      debug address
//  dbg_wdata  in   DATA_BUS_WIDTH  debug write data
//  dbg_rdata  out  DATA_BUS_WIDTH  read data returned to debug port
//  dbg_done   out  1               1-cycle pulse: debug transaction complete
//  mem_op     out  mem_ctrl_op_e   op to memory controller
//  mem_addr   out  ADDR_WIDTH      address to memory controller
//  mem_wdata  out  DATA_BUS_WIDTH  write data to memory controller
//  mem_rdata  in   DATA_BUS_WIDTH  read data from memory controller
//  mem_done   in   1               memory controller op complete
//  grant_dbg  out  1               1 while the debug port owns the bus
//  timeout_err out 1               sticky; set on any grant timeout
// BEHAVIOUR
//  - Reset values (any cycle with reset=1, including mid-transaction):
//    - mem_op=MEM_NOP; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0.
//    - cpu_done, dbg_done, grant_dbg, timeout_err = 0; wait counter = 0.
//    - state=IDLE; last_served=DBG, so the CPU wins the first tie.
//  - A request is any op other than MEM_NOP. Any undefined encoding is treated as MEM_NOP.
//  - All outputs are registered.
//  - FSM: IDLE -> GRANT_CPU | GRANT_DBG -> RELEASE -> IDLE.
//  - IDLE:
//    - Samples requests.
//    - Both requesting: grant goes to the one that is not last_served. One requesting: grant goes to it. None: stay in IDLE.
//    - On grant, latch the winner's op/addr/wdata into mem_op/mem_addr/mem_wdata at the same edge.
//    - Grant latency: request seen in IDLE at cycle n -> mem_op valid at n+1.
//    - grant_dbg is set at the same edge as a debug grant.
//  - GRANT_x:
//    - mem_op/addr/wdata are held constant. Requester input changes during the grant are ignored.
//    - On mem_done=1 (cycle m):
//      - x_rdata <= mem_rdata for reads; x_rdata is unchanged for writes.
//      - x_done pulses at m+1 for exactly one cycle.
//      - mem_op <= MEM_NOP; last_served <= x; go to RELEASE.
//  - RELEASE:
//    - Lasts exactly 1 cycle; grant_dbg clears; all requests are ignored (the served requester's op may still be stale).
//    - Then IDLE. A re-arbitration gap of 1 cycle is mandatory.
//  - Timeout:
//    - The wait counter increments each GRANT cycle without mem_done.
//    - When the count reaches MAX_WAIT:
//      - timeout_err <= 1; mem_op <= MEM_NOP.
//      - x_done pulses; x_rdata <= all ones; go to RELEASE.
//    - The counter clears on leaving GRANT.
//    - mem_done in the same cycle as timeout: treat as normal completion, no error.
//  - mem_done outside GRANT states is ignored.
//  - Starvation bound: with both ports requesting continuously, service strictly alternates CPU, DBG, CPU, ...
// TESTING
//  - Reset -> all outputs at reset values; reset asserted mid-GRANT_CPU -> mem_op=MEM_NOP next cycle, no cpu_done.
//  - CPU read only, addr 0x12, mem_done 3 cycles later with rdata 0xA5 -> mem_op=READ @+1, cpu_rdata=0xA5 and cpu_done 1 cycle, dbg_done never.
//  - Both request in the same cycle after reset -> CPU served first, then DBG; the next tie goes to CPU again (alternation over 4 transactions).
//  - DBG write 0x3C to 0x80 while cpu_op changes mid-grant -> mem_addr/mem_wdata stay 0x80/0x3C until done, grant_dbg high throughout.
//  - mem_done held 0 for MAX_WAIT cycles -> timeout_err=1, requester done pulse with rdata=0xFF, arbiter back in IDLE 2 cycles later.
//  - mem_done pulse while IDLE -> no done outputs, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single memory controller between the CPU control FSM
//   (primary requester) and the debug/loader port (secondary requester).
//   Grants alternate round-robin; each grant is held for exactly one
//   memory transaction, after which read data and a one-cycle done pulse
//   are returned to the winner.  A mandatory one-cycle RELEASE gap
//   separates consecutive grants.
//
// Op encoding (mem_ctrl_op_e): 2'd0 MEM_NOP, 2'd1 MEM_READ, 2'd2 MEM_WRITE.
// Encoding 2'd3 is undefined and treated as MEM_NOP.
//
// Ports
//   clock, reset            system clock; synchronous active-high reset
//   cpu_op/addr/wdata       CPU request
//   cpu_rdata, cpu_done     CPU read data and completion pulse
//   dbg_op/addr/wdata       debug request
//   dbg_rdata, dbg_done     debug read data and completion pulse
//   mem_op/addr/wdata       request presented to the memory controller
//   mem_rdata, mem_done     memory controller response
//   grant_dbg               high while the debug port owns the bus
//   timeout_err             sticky; set when a grant times out
module mem_bus_arbiter #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_WAIT       = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                cpu_op,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_wdata,
  output logic [DATA_BUS_WIDTH-1:0] cpu_rdata,
  output logic                      cpu_done,
  input  logic [1:0]                dbg_op,
  input  logic [ADDR_WIDTH-1:0]     dbg_addr,
  input  logic [DATA_BUS_WIDTH-1:0] dbg_wdata,
  output logic [DATA_BUS_WIDTH-1:0] dbg_rdata,
  output logic                      dbg_done,
  output logic [1:0]                mem_op,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  input  logic                      mem_done,
  output logic                      grant_dbg,
  output logic                      timeout_err
);

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_CPU = 2'd1;
  localparam logic [1:0] ST_GRANT_DBG = 2'd2;
  localparam logic [1:0] ST_RELEASE   = 2'd3;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // Count value at the start of the MAX_WAIT-th grant cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]       state;
  logic             last_dbg;   // 1 when the debug port was served last
  logic [CNT_W-1:0] wait_cnt;

  logic cpu_req;
  logic dbg_req;
  logic pick_dbg;
  logic in_grant;
  logic serving_dbg;
  logic finish;
  logic mem_is_read;

  function automatic logic is_req(input logic [1:0] op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

  always_comb begin
    cpu_req     = is_req(cpu_op);
    dbg_req     = is_req(dbg_op);
    // Debug wins only when it is alone or the CPU was served last.
    pick_dbg    = dbg_req && (!cpu_req || !last_dbg);
    in_grant    = (state == ST_GRANT_CPU) || (state == ST_GRANT_DBG);
    serving_dbg = (state == ST_GRANT_DBG);
    // mem_done takes priority over a timeout landing in the same cycle.
    finish      = mem_done || (wait_cnt == WAIT_LAST);
    mem_is_read = (mem_op == MEM_READ);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_dbg    <= 1'b1;
      wait_cnt    <= '0;
      mem_op      <= MEM_NOP;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      cpu_done    <= 1'b0;
      dbg_done    <= 1'b0;
      grant_dbg   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            state     <= pick_dbg ? ST_GRANT_DBG : ST_GRANT_CPU;
            grant_dbg <= pick_dbg;
            mem_op    <= pick_dbg ? dbg_op    : cpu_op;
            mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ST_GRANT_CPU, ST_GRANT_DBG: begin
          if (in_grant && finish) begin
            state     <= ST_RELEASE;
            mem_op    <= MEM_NOP;
            wait_cnt  <= '0;
            grant_dbg <= 1'b0;
            last_dbg  <= serving_dbg;
            if (!mem_done) begin
              timeout_err <= 1'b1;
            end
            if (serving_dbg) begin
              dbg_done <= 1'b1;
              if (!mem_done) begin
                dbg_rdata <= '1;
              end else if (mem_is_read) begin
                dbg_rdata <= mem_rdata;
              end
            end else begin
              cpu_done <= 1'b1;
              if (!mem_done) begin
                cpu_rdata <= '1;
              end else if (mem_is_read) begin
                cpu_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int MW = 8;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] WR  = 2'd2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cpu_op = NOP;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  logic [1:0]    dbg_op = NOP;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done = 1'b0;
  logic          grant_dbg;
  logic          timeout_err;

  mem_bus_arbiter #(
    .DATA_BUS_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_WAIT(MW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_op(cpu_op),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done),
    .dbg_op(dbg_op),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_done(dbg_done),
    .mem_op(mem_op),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done(mem_done),
    .grant_dbg(grant_dbg),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // who: 1 = debug port, 0 = CPU
  typedef struct packed {
    logic          who;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_cpu_r = '0;
  logic [DW-1:0] exp_dbg_r = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_done(input logic who, input logic [DW-1:0] d);
    exp_t e;
    e.who   = who;
    e.rdata = d;
    sb.push_back(e);
    if (who) exp_dbg_r = d;
    else     exp_cpu_r = d;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (mem_op == NOP && n < 50) begin
      tick();
      n++;
    end
    check("grant_seen", 32'(mem_op != NOP), 1);
  endtask

  task automatic finish_txn(input int lat, input logic [DW-1:0] d);
    repeat (lat) tick();
    mem_done  = 1'b1;
    mem_rdata = d;
    tick();
    mem_done  = 1'b0;
    check("op_cleared", mem_op, NOP);
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    cpu_op   = NOP;
    dbg_op   = NOP;
    mem_done = 1'b0;
    tick();
    tick();
    check("rst_mem_op", mem_op, NOP);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_dones", {cpu_done, dbg_done}, 0);
    check("rst_grant_dbg", grant_dbg, 0);
    check("rst_timeout", timeout_err, 0);
    reset     = 1'b0;
    exp_cpu_r = '0;
    exp_dbg_r = '0;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (cpu_done || dbg_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {cpu_done, dbg_done}, 0);
      end else begin
        e = sb.pop_front();
        check("done_who", {cpu_done, dbg_done}, e.who ? 2'b01 : 2'b10);
        check("done_rdata", e.who ? dbg_rdata : cpu_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    // Reset values
    reset_dut();

    // CPU read, single requester, 1-cycle grant latency
    cpu_op   = RD;
    cpu_addr = 8'h12;
    tick();
    check("cpu_rd_latency", mem_op, RD);
    check("cpu_rd_addr", mem_addr, 8'h12);
    check("cpu_rd_grant_dbg", grant_dbg, 0);
    cpu_op = NOP;
    expect_done(1'b0, 8'hA5);
    finish_txn(2, 8'hA5);
    tick();

    // Continuous ties after reset alternate CPU, DBG, CPU, DBG
    reset_dut();
    cpu_op    = RD;
    cpu_addr  = 8'h21;
    dbg_op    = WR;
    dbg_addr  = 8'h31;
    dbg_wdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      check("alt_grant_dbg", grant_dbg, 32'(i % 2));
      check("alt_addr", mem_addr, (i % 2 == 1) ? 8'h31 : 8'h21);
      if (i % 2 == 1) expect_done(1'b1, exp_dbg_r);
      else            expect_done(1'b0, 8'(8'h40 + i));
      finish_txn(1, 8'(8'h40 + i));
      if (i == 3) begin
        cpu_op = NOP;
        dbg_op = NOP;
      end
    end

    // Debug write held stable while requester inputs change mid-grant
    dbg_op    = WR;
    dbg_addr  = 8'h80;
    dbg_wdata = 8'h3C;
    wait_grant();
    check("dbgw_grant", grant_dbg, 1);
    cpu_op    = RD;
    cpu_addr  = 8'h11;
    dbg_op    = RD;
    dbg_addr  = 8'h99;
    dbg_wdata = 8'h00;
    expect_done(1'b1, exp_dbg_r);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("dbgw_hold_op", mem_op, WR);
      check("dbgw_hold_addr", mem_addr, 8'h80);
      check("dbgw_hold_wdata", mem_wdata, 8'h3C);
      check("dbgw_hold_grant", grant_dbg, 1);
    end
    mem_done  = 1'b1;
    mem_rdata = 8'hEE;
    tick();
    mem_done = 1'b0;
    dbg_op   = NOP;
    check("dbgw_release_grant", grant_dbg, 0);
    // The CPU read raised during the debug grant is served next
    expect_done(1'b0, 8'h5B);
    wait_grant();
    check("pend_cpu_addr", mem_addr, 8'h11);
    cpu_op = NOP;
    finish_txn(0, 8'h5B);
    tick();

    // Timeout: no mem_done for MAX_WAIT grant cycles
    cpu_op   = RD;
    cpu_addr = 8'h44;
    wait_grant();
    cpu_op = NOP;
    expect_done(1'b0, 8'hFF);
    repeat (MW - 1) tick();
    check("to_not_yet", timeout_err, 0);
    check("to_still_granted", mem_op, RD);
    tick();
    check("to_err_set", timeout_err, 1);
    check("to_op_cleared", mem_op, NOP);
    dbg_op    = WR;
    dbg_addr  = 8'h55;
    dbg_wdata = 8'h01;
    tick();
    check("to_release_gap", mem_op, NOP);
    tick();
    check("to_idle_regrant", mem_op, WR);
    check("to_idle_grant_dbg", grant_dbg, 1);
    dbg_op = NOP;
    expect_done(1'b1, exp_dbg_r);
    finish_txn(0, 8'h00);
    check("to_err_sticky", timeout_err, 1);
    tick();

    // mem_done in the same cycle the count reaches MAX_WAIT: normal completion
    reset_dut();
    cpu_op   = RD;
    cpu_addr = 8'h45;
    wait_grant();
    cpu_op = NOP;
    expect_done(1'b0, 8'h66);
    repeat (MW - 1) tick();
    mem_done  = 1'b1;
    mem_rdata = 8'h66;
    tick();
    mem_done = 1'b0;
    check("edge_no_err", timeout_err, 0);
    check("edge_op_cleared", mem_op, NOP);
    tick();
    tick();

    // mem_done while IDLE is ignored
    mem_done  = 1'b1;
    mem_rdata = 8'h99;
    tick();
    mem_done = 1'b0;
    check("idle_done_op", mem_op, NOP);
    check("idle_done_grant", grant_dbg, 0);
    check("idle_done_rdata", cpu_rdata, exp_cpu_r);
    tick();
    cpu_op   = RD;
    cpu_addr = 8'h46;
    tick();
    check("idle_still_idle", mem_op, RD);

    // Reset mid-GRANT_CPU, with mem_done offered at the reset edge
    cpu_op = NOP;
    tick();
    reset     = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 8'h33;
    tick();
    check("midrst_op", mem_op, NOP);
    check("midrst_cpu_done", cpu_done, 0);
    check("midrst_cpu_rdata", cpu_rdata, 0);
    check("midrst_grant", grant_dbg, 0);
    reset     = 1'b0;
    mem_done  = 1'b0;
    exp_cpu_r = '0;
    exp_dbg_r = '0;

    // Recovery: both request, CPU wins the first tie after reset
    cpu_op    = RD;
    cpu_addr  = 8'h47;
    dbg_op    = RD;
    dbg_addr  = 8'h48;
    tick();
    check("post_rst_op", mem_op, RD);
    check("post_rst_cpu_wins", mem_addr, 8'h47);
    cpu_op = NOP;
    dbg_op = NOP;
    expect_done(1'b0, 8'hC3);
    finish_txn(1, 8'hC3);
    tick();
    tick();

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
